cpu_io_serializer: RTL and testbench

- Peripheral on the far side of the core's memory-mapped GPIO ports. It consumes the core's output words (io2_out, io3_out) and produces the core's io0_in status word.
- Every change on either output word is queued in a small FIFO, then sent out on a UART 8N1 line as a 5-byte tagged frame.
- The core reads io0_in to get FIFO space and overflow status, which gives software flow control.

---
 rtl/cpu_io_serializer.sv | 179 +++++++++++++++++
 tb/tb_cpu_io_serializer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_io_serializer.sv
// GPIO-side peripheral: queues changes on io2_out/io3_out and sends each as a 5-byte tagged UART frame.
// Define IO_SERIAL_PARITY_EN to switch the line format from 8N1 to 8E1.
module cpu_io_serializer #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] io2_out,
    input  logic [31:0] io3_out,
    output logic [31:0] io0_in,
    output logic        tx
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(CLKS_PER_BIT - 1);

`ifdef IO_SERIAL_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    logic          r_armed;
    logic [31:0]   r_prev2, r_prev3;
    logic [32:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_ovf;
    logic [31:0]   r_io0;
    state_t        r_state, w_state_n;
    logic [BW-1:0] r_baud, w_baud_n;
    logic [2:0]    r_bit, w_bit_n;
    logic [2:0]    r_byte, w_byte_n;
    logic [39:0]   r_shift, w_shift_n;
    logic          r_tx, w_tx_n;

    logic          w_ch2, w_ch3, w_acc2, w_acc3, w_pop, w_tick, w_busy;
    logic [CW-1:0] w_free;
    logic [1:0]    w_ndrop;
    logic [8:0]    w_ovf_sum;
    logic [32:0]   w_head;

    assign w_ch2     = r_armed && (io2_out != r_prev2);
    assign w_ch3     = r_armed && (io3_out != r_prev3);
    assign w_free    = DEPTH_C - r_count;
    // io3 only fits if a slot remains after io2 has taken its one
    assign w_acc2    = w_ch2 && (w_free != '0);
    assign w_acc3    = w_ch3 && (w_free > (w_acc2 ? CW'(1) : CW'(0)));
    assign w_ndrop   = {1'b0, w_ch2 && !w_acc2} + {1'b0, w_ch3 && !w_acc3};
    assign w_ovf_sum = {1'b0, r_ovf} + {7'd0, w_ndrop};
    assign w_pop     = (r_state == S_IDLE) && (r_count != '0);
    assign w_head    = r_mem[r_rptr];
    assign w_tick    = (r_baud == BIT_LAST);
    assign w_busy    = (r_state != S_IDLE) || (r_count != '0);

    assign io0_in = r_io0;
    assign tx     = r_tx;

    always_ff @(posedge clk) begin
        if (w_acc2) r_mem[r_wptr] <= {1'b0, io2_out};
        if (w_acc3) r_mem[w_acc2 ? r_wptr + AW'(1) : r_wptr] <= {1'b1, io3_out};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed <= 1'b0;
            r_prev2 <= '0;
            r_prev3 <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= '0;
            r_io0   <= {24'd0, 8'(FIFO_DEPTH)};
        end else begin
            r_armed <= 1'b1;
            r_prev2 <= io2_out;
            r_prev3 <= io3_out;
            r_wptr  <= r_wptr + AW'(w_acc2) + AW'(w_acc3);
            r_rptr  <= r_rptr + AW'(w_pop);
            r_count <= r_count + CW'(w_acc2) + CW'(w_acc3) - CW'(w_pop);
            r_ovf   <= w_ovf_sum[8] ? 8'hFF : w_ovf_sum[7:0];
            r_io0   <= {15'd0, w_busy, r_ovf, 8'(w_free)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_n;
            r_baud  <= w_baud_n;
            r_bit   <= w_bit_n;
            r_byte  <= w_byte_n;
            r_shift <= w_shift_n;
            r_tx    <= w_tx_n;
        end
    end

    // tx is computed for the state being entered so the line level lines up with the state
    always_comb begin
        w_state_n = r_state;
        w_baud_n  = r_baud;
        w_bit_n   = r_bit;
        w_byte_n  = r_byte;
        w_shift_n = r_shift;
        w_tx_n    = r_tx;
        if (r_state != S_IDLE) w_baud_n = w_tick ? '0 : r_baud + BW'(1);
        case (r_state)
            S_IDLE: begin
                w_baud_n = '0;
                w_tx_n   = 1'b1;
                if (w_pop) begin
                    w_shift_n = {w_head[31:0], 7'b0000001, w_head[32]};
                    w_byte_n  = '0;
                    w_state_n = S_START;
                    w_tx_n    = 1'b0;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_state_n = S_DATA;
                    w_bit_n   = '0;
                    w_tx_n    = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    if (r_bit == 3'd7) begin
`ifdef IO_SERIAL_PARITY_EN
                        w_state_n = S_PARITY;
                        w_tx_n    = ^r_shift[7:0];
`else
                        w_state_n = S_STOP;
                        w_tx_n    = 1'b1;
`endif
                    end else begin
                        w_bit_n = r_bit + 3'd1;
                        w_tx_n  = r_shift[r_bit + 3'd1];
                    end
                end
            end
`ifdef IO_SERIAL_PARITY_EN
            S_PARITY: begin
                if (w_tick) begin
                    w_state_n = S_STOP;
                    w_tx_n    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (w_tick) begin
                    if (r_byte != 3'd4) begin
                        w_byte_n  = r_byte + 3'd1;
                        w_shift_n = {8'd0, r_shift[39:8]};
                        w_state_n = S_START;
                        w_tx_n    = 1'b0;
                    end else begin
                        w_state_n = S_IDLE;
                        w_tx_n    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_tx_n    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_io_serializer.sv
// Bench for cpu_io_serializer: a UART receiver model collects bytes, tasks compare them against a queue of expected bytes.
module tb_cpu_io_serializer;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef IO_SERIAL_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] io2_out = '0;
    logic [31:0] io3_out = '0;
    logic [31:0] io0_in;
    logic        tx;

    cpu_io_serializer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .io2_out(io2_out), .io3_out(io3_out),
        .io0_in(io0_in), .tx(tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stp;
        int         cyc;
    } rx_t;

    rx_t        rx_q[$];
    logic [7:0] exp_q[$];
    int         cyc = 0;
    int         checks = 0;
    int         passes = 0;

    always @(posedge clk) cyc <= cyc + 1;

    rx_t rx_cur;
    bit  rx_abort;
    int  rx_idx;

    // Receiver: samples mid-bit on negedges, drops any byte cut short by reset.
    initial begin : receiver
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                rx_cur.data = '0;
                rx_cur.par  = 1'b0;
                rx_cur.stp  = 1'b0;
                rx_cur.cyc  = cyc;
                rx_abort    = 1'b0;
                for (int k = 1; k <= CPB * (NB - 1) + CPB / 2; k++) begin
                    @(negedge clk);
                    if (rst_n !== 1'b1) begin rx_abort = 1'b1; break; end
                    if (k % CPB == CPB / 2) begin
                        rx_idx = k / CPB;
                        if (rx_idx == 0) begin
                            if (tx !== 1'b0) begin rx_abort = 1'b1; break; end
                        end else if (rx_idx <= 8) rx_cur.data[rx_idx-1] = tx;
                        else if (rx_idx == NB - 1) rx_cur.stp = tx;
                        else if (rx_idx == 9) rx_cur.par = tx;
                    end
                end
                if (!rx_abort) rx_q.push_back(rx_cur);
            end
        end
    end

    task automatic wait_rx(input int n, input int budget, output bit to);
        for (int i = 0; i < budget && rx_q.size() < n; i++) @(negedge clk);
        to = (rx_q.size() < n);
    endtask

    task automatic push_frame(input logic [7:0] tag, input logic [31:0] d);
        exp_q.push_back(tag);
        exp_q.push_back(d[7:0]);
        exp_q.push_back(d[15:8]);
        exp_q.push_back(d[23:16]);
        exp_q.push_back(d[31:24]);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        io2_out = $urandom | 32'h8000_0000;
        io3_out = $urandom | 32'h8000_0000;
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else passes++;
        checks++;
        if (io0_in !== 32'h0000_0004) $display("FAIL reset_io0: got %08h want 00000004", io0_in);
        else passes++;
        rst_n = 1'b1;
    endtask

    task automatic test_arming();
        bit low = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (tx !== 1'b1) low = 1'b1;
        end
        checks++;
        if (low) $display("FAIL arming_tx_idle: got tx low, want 1 throughout"); else passes++;
        checks++;
        if (rx_q.size() != 0) $display("FAIL arming_no_bytes: got %0d bytes want 0", rx_q.size());
        else passes++;
        checks++;
        if (io0_in !== 32'h0000_0004) $display("FAIL arming_io0: got %08h want 00000004", io0_in);
        else passes++;
    endtask

    task automatic test_single();
        bit to;
        rx_t r;
        logic [7:0] e;
        int prev = 0;
        io2_out = 32'h1234_5678;
        push_frame(8'h02, 32'h1234_5678);
        repeat (5) @(negedge clk);
        checks++;
        if (io0_in[16] !== 1'b1) $display("FAIL single_busy: got %b want 1", io0_in[16]); else passes++;
        checks++;
        if (io0_in[7:0] !== 8'd4) $display("FAIL single_free: got %0d want 4", io0_in[7:0]); else passes++;
        wait_rx(exp_q.size(), 400, to);
        checks++;
        if (to) $display("FAIL single_timeout: got %0d bytes want %0d", rx_q.size(), exp_q.size());
        else passes++;
        for (int j = 0; exp_q.size() > 0 && rx_q.size() > 0; j++) begin
            e = exp_q.pop_front();
            r = rx_q.pop_front();
            checks++;
            if (r.data !== e || r.stp !== 1'b1)
                $display("FAIL single_byte%0d: got %02h stop %b want %02h stop 1", j, r.data, r.stp, e);
            else passes++;
            if (j > 0) begin
                checks++;
                if (r.cyc - prev != NB * CPB)
                    $display("FAIL single_spacing%0d: got %0d cycles want %0d", j, r.cyc - prev, NB * CPB);
                else passes++;
            end
            prev = r.cyc;
        end
        exp_q.delete();
        repeat (4) @(negedge clk);
        checks++;
        if (io0_in !== 32'h0000_0004) $display("FAIL single_idle_io0: got %08h want 00000004", io0_in);
        else passes++;
    endtask

    task automatic test_back_to_back();
        bit to;
        rx_t r;
        logic [7:0] e;
        int prev = 0;
        int want;
        io2_out = 32'h0000_000A;
        io3_out = 32'h0000_000B;
        push_frame(8'h02, 32'h0000_000A);
        push_frame(8'h03, 32'h0000_000B);
        wait_rx(exp_q.size(), 800, to);
        checks++;
        if (to) $display("FAIL b2b_timeout: got %0d bytes want %0d", rx_q.size(), exp_q.size());
        else passes++;
        for (int j = 0; exp_q.size() > 0 && rx_q.size() > 0; j++) begin
            e = exp_q.pop_front();
            r = rx_q.pop_front();
            checks++;
            if (r.data !== e || r.stp !== 1'b1)
                $display("FAIL b2b_byte%0d: got %02h stop %b want %02h stop 1", j, r.data, r.stp, e);
            else passes++;
            if (j > 0) begin
                want = (j == 5) ? NB * CPB + 1 : NB * CPB;
                checks++;
                if (r.cyc - prev != want)
                    $display("FAIL b2b_spacing%0d: got %0d cycles want %0d", j, r.cyc - prev, want);
                else passes++;
            end
            prev = r.cyc;
        end
        exp_q.delete();
        repeat (4) @(negedge clk);
        checks++;
        if (io0_in !== 32'h0000_0004) $display("FAIL b2b_idle_io0: got %08h want 00000004", io0_in);
        else passes++;
    endtask

    task automatic test_overflow();
        bit to;
        rx_t r;
        logic [7:0] e;
        for (int i = 1; i <= 6; i++) begin
            io2_out = 32'h100 + i;
            if (i <= 5) push_frame(8'h02, 32'h100 + i);
            @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if (io0_in[15:8] !== 8'd1) $display("FAIL ovf_count: got %0d want 1", io0_in[15:8]); else passes++;
        checks++;
        if (io0_in[7:0] !== 8'd0) $display("FAIL ovf_free: got %0d want 0", io0_in[7:0]); else passes++;
        wait_rx(exp_q.size(), 5 * 300, to);
        checks++;
        if (to) $display("FAIL ovf_timeout: got %0d bytes want %0d", rx_q.size(), exp_q.size());
        else passes++;
        for (int j = 0; exp_q.size() > 0 && rx_q.size() > 0; j++) begin
            e = exp_q.pop_front();
            r = rx_q.pop_front();
            checks++;
            if (r.data !== e || r.stp !== 1'b1)
                $display("FAIL ovf_byte%0d: got %02h stop %b want %02h stop 1", j, r.data, r.stp, e);
            else passes++;
        end
        exp_q.delete();
        repeat (4) @(negedge clk);
        checks++;
        if (io0_in !== 32'h0000_0104) $display("FAIL ovf_sticky_io0: got %08h want 00000104", io0_in);
        else passes++;
    endtask

    task automatic test_reset_midframe();
        bit to;
        bit low = 1'b0;
        rx_t r;
        io3_out = 32'h55AA_1234;
        wait_rx(1, 300, to);
        checks++;
        if (to) $display("FAIL midrst_timeout: got no byte want 1");
        else begin
            r = rx_q.pop_front();
            if (r.data !== 8'h03) $display("FAIL midrst_tag: got %02h want 03", r.data); else passes++;
        end
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1) $display("FAIL midrst_tx: got %b want 1", tx); else passes++;
        checks++;
        if (io0_in !== 32'h0000_0004) $display("FAIL midrst_io0: got %08h want 00000004", io0_in);
        else passes++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (150) begin
            @(negedge clk);
            if (tx !== 1'b1) low = 1'b1;
        end
        checks++;
        if (low) $display("FAIL midrst_resume: got tx low after release, want idle"); else passes++;
        checks++;
        if (rx_q.size() != 0) $display("FAIL midrst_bytes: got %0d bytes want 0", rx_q.size());
        else passes++;
        checks++;
        if (io0_in !== 32'h0000_0004) $display("FAIL midrst_after_io0: got %08h want 00000004", io0_in);
        else passes++;
    endtask

    task automatic test_parity();
        bit to;
        rx_t r;
        logic [7:0] e;
        int prev = 0;
        io3_out = 32'h0000_0007;
        push_frame(8'h03, 32'h0000_0007);
        wait_rx(exp_q.size(), 400, to);
        checks++;
        if (to) $display("FAIL par_timeout: got %0d bytes want %0d", rx_q.size(), exp_q.size());
        else passes++;
        for (int j = 0; exp_q.size() > 0 && rx_q.size() > 0; j++) begin
            e = exp_q.pop_front();
            r = rx_q.pop_front();
            checks++;
            if (r.data !== e || r.stp !== 1'b1)
                $display("FAIL par_byte%0d: got %02h stop %b want %02h stop 1", j, r.data, r.stp, e);
            else passes++;
`ifdef IO_SERIAL_PARITY_EN
            checks++;
            if (r.par !== ^e) $display("FAIL par_bit%0d: got %b want %b", j, r.par, ^e); else passes++;
`endif
            if (j > 0) begin
                checks++;
                if (r.cyc - prev != NB * CPB)
                    $display("FAIL par_spacing%0d: got %0d cycles want %0d", j, r.cyc - prev, NB * CPB);
                else passes++;
            end
            prev = r.cyc;
        end
        exp_q.delete();
        repeat (4) @(negedge clk);
        checks++;
        if (io0_in !== 32'h0000_0004) $display("FAIL par_idle_io0: got %08h want 00000004", io0_in);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_arming();
        test_single();
        test_back_to_back();
        test_overflow();
        test_reset_midframe();
        test_parity();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
